// File: rtl/waveform_pkg.sv
// Shared definitions for the waveform generator / analyzer chain.
// The generator side reuses DATA_W.
package waveform_pkg;

  typedef enum logic [1:0] {
    INIT,
    RISE,
    FALL
  } state_t;

  localparam int DATA_W   = 12;
  localparam int HYST_DEF = 4;
  localparam int PERIOD_W = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and synchronous load-to-1.
// Used as the sample-period counter of the triangle analyzer.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      if (load) begin
        cnt <= W'(1);
      end else if (cnt != '1) begin
        cnt <= cnt + W'(1);
      end
    end
  end

endmodule

// File: rtl/triangle_wave_analyzer.sv
// Slope tracker with hysteresis: detects peaks/troughs of a sample stream and
// reports period, max, min and amplitude once per trough-to-trough cycle.
module triangle_wave_analyzer #(
  parameter int DATA_W   = waveform_pkg::DATA_W,
  parameter int HYST     = waveform_pkg::HYST_DEF,
  parameter int PERIOD_W = waveform_pkg::PERIOD_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   sample_in,
  input  logic                sample_valid,
  output logic [PERIOD_W-1:0] period_out,
  output logic [DATA_W-1:0]   max_out,
  output logic [DATA_W-1:0]   min_out,
  output logic [DATA_W-1:0]   amplitude_out,
  output logic                result_valid,
  output logic                direction_out,
  output logic                locked
);

  import waveform_pkg::*;

  localparam logic [DATA_W:0] HYST_X = (DATA_W+1)'(HYST);

  state_t              state;
  logic [DATA_W-1:0]   run_max;
  logic [DATA_W-1:0]   run_min;
  logic [DATA_W-1:0]   peak_val;
  logic [PERIOD_W-1:0] cnt;
  logic                peak_hit;
  logic                trough_hit;
  logic                cnt_load;

  // Comparisons are one bit wider so s + HYST never wraps near full scale.
  always_comb begin
    peak_hit   = (state == RISE) &&
                 (({1'b0, sample_in} + HYST_X) <= {1'b0, run_max});
    trough_hit = (state == FALL) &&
                 ({1'b0, sample_in} >= ({1'b0, run_min} + HYST_X));
    cnt_load   = (state == INIT) || trough_hit;
  end

  sat_counter #(
    .W(PERIOD_W)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .en  (sample_valid),
    .load(cnt_load),
    .cnt (cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= INIT;
      run_max       <= '0;
      run_min       <= '0;
      peak_val      <= '0;
      period_out    <= '0;
      max_out       <= '0;
      min_out       <= '0;
      amplitude_out <= '0;
      result_valid  <= 1'b0;
      direction_out <= 1'b1;
      locked        <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (sample_valid) begin
        case (state)
          INIT: begin
            run_max       <= sample_in;
            run_min       <= sample_in;
            state         <= RISE;
            direction_out <= 1'b1;
          end
          RISE: begin
            if (peak_hit) begin
              peak_val      <= run_max;
              run_min       <= sample_in;
              state         <= FALL;
              direction_out <= 1'b0;
            end else if (sample_in > run_max) begin
              run_max <= sample_in;
            end
          end
          FALL: begin
            if (trough_hit) begin
              if (locked) begin
                period_out    <= cnt;
                max_out       <= peak_val;
                min_out       <= run_min;
                amplitude_out <= peak_val - run_min;
                result_valid  <= 1'b1;
              end
              locked        <= 1'b1;
              run_max       <= sample_in;
              state         <= RISE;
              direction_out <= 1'b1;
            end else if (sample_in < run_min) begin
              run_min <= sample_in;
            end
          end
          default: begin
            state         <= INIT;
            direction_out <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_triangle_wave_analyzer.sv
// Directed bench for triangle_wave_analyzer: sweeps, gaps, noise, full-scale,
// period saturation (second instance with PERIOD_W=4) and mid-cycle reset.
module tb_triangle_wave_analyzer;

  logic        clk;
  logic        rst;
  logic [11:0] sample_in;
  logic        sample_valid;

  logic [15:0] period_out;
  logic [11:0] max_out, min_out, amplitude_out;
  logic        result_valid, direction_out, locked;

  logic [3:0]  s_period_out;
  logic [11:0] s_max_out, s_min_out, s_amplitude_out;
  logic        s_result_valid, s_direction_out, s_locked;

  int unsigned total = 0;
  int unsigned bad   = 0;

  triangle_wave_analyzer #(
    .DATA_W  (12),
    .HYST    (4),
    .PERIOD_W(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .period_out   (period_out),
    .max_out      (max_out),
    .min_out      (min_out),
    .amplitude_out(amplitude_out),
    .result_valid (result_valid),
    .direction_out(direction_out),
    .locked       (locked)
  );

  triangle_wave_analyzer #(
    .DATA_W  (12),
    .HYST    (4),
    .PERIOD_W(4)
  ) dut_sat (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .period_out   (s_period_out),
    .max_out      (s_max_out),
    .min_out      (s_min_out),
    .amplitude_out(s_amplitude_out),
    .result_valid (s_result_valid),
    .direction_out(s_direction_out),
    .locked       (s_locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [11:0] s, input logic v);
    @(negedge clk);
    sample_in    = s;
    sample_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic do_rst();
    @(negedge clk);
    rst          = 1'b1;
    sample_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic chk_reset_vals();
    chk("rst period", 32'(period_out), 32'd0);
    chk("rst max", 32'(max_out), 32'd0);
    chk("rst min", 32'(min_out), 32'd0);
    chk("rst amp", 32'(amplitude_out), 32'd0);
    chk("rst rv", 32'(result_valid), 32'd0);
    chk("rst dir", 32'(direction_out), 32'd1);
    chk("rst locked", 32'(locked), 32'd0);
  endtask

  // Triangle 0, step, ..., half*step, ..., step, repeating every 2*half samples.
  // toff = samples needed past an extremum to cover HYST (ceil(4/step)).
  task automatic run_stream(input int unsigned half, input int unsigned step,
                            input int unsigned nsamp, input int unsigned toff,
                            input bit gap, input bit sat);
    int unsigned p = 2 * half;
    for (int unsigned n = 0; n < nsamp; n++) begin
      int unsigned m = n % p;
      int unsigned v = (m <= half) ? m * step : (p - m) * step;
      bit exp_rv   = (n >= 2 * p + toff) && (m == toff);
      bit exp_lock = (n >= p + toff);
      bit exp_fall = (m >= half + toff) || ((n >= p) && (m < toff));
      logic        o_rv   = sat ? s_result_valid  : result_valid;
      logic        o_lock = sat ? s_locked        : locked;
      logic        o_dir  = sat ? s_direction_out : direction_out;
      drive(12'(v), 1'b1);
      o_rv   = sat ? s_result_valid  : result_valid;
      o_lock = sat ? s_locked        : locked;
      o_dir  = sat ? s_direction_out : direction_out;
      chk("result_valid", 32'(o_rv), 32'(exp_rv));
      chk("locked", 32'(o_lock), 32'(exp_lock));
      chk("direction", 32'(o_dir), 32'(!exp_fall));
      if (exp_rv) begin
        if (sat) begin
          chk("sat period", 32'(s_period_out), 32'd15);
          chk("sat max", 32'(s_max_out), 32'(half * step));
          chk("sat min", 32'(s_min_out), 32'd0);
          chk("sat amp", 32'(s_amplitude_out), 32'(half * step));
        end else begin
          chk("period", 32'(period_out), 32'(p));
          chk("max", 32'(max_out), 32'(half * step));
          chk("min", 32'(min_out), 32'd0);
          chk("amp", 32'(amplitude_out), 32'(half * step));
        end
      end
      if (gap) begin
        drive(12'hABC, 1'b0);
        chk("gap rv low", 32'(result_valid), 32'd0);
        chk("gap dir hold", 32'(direction_out), 32'(!exp_fall));
        if (exp_rv) chk("gap period hold", 32'(period_out), 32'(p));
      end
    end
  endtask

  initial begin
    rst          = 1'b1;
    sample_in    = '0;
    sample_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_reset_vals();

    // Triangle sweep 0..100 step 2: results at 202, 302, 402
    run_stream(50, 2, 406, 2, 1'b0, 1'b0);

    // Same stream, sample_valid low on every other cycle
    do_rst();
    chk_reset_vals();
    run_stream(50, 2, 306, 2, 1'b1, 1'b0);

    // Sub-hysteresis noise
    do_rst();
    for (int unsigned i = 0; i < 20; i++) begin
      drive((i % 2 == 0) ? 12'd50 : 12'd52, 1'b1);
      chk("noise rv", 32'(result_valid), 32'd0);
      chk("noise dir", 32'(direction_out), 32'd1);
    end
    chk("noise locked", 32'(locked), 32'd0);

    // Full-scale sweep in 0x100 steps: peak 0xF00
    do_rst();
    run_stream(15, 256, 126, 1, 1'b0, 1'b0);

    // 40-sample period into the PERIOD_W=4 instance
    do_rst();
    run_stream(20, 2, 166, 2, 1'b0, 1'b1);

    // Reset during FALL after a result exists, then restart from scratch
    do_rst();
    run_stream(50, 2, 261, 2, 1'b0, 1'b0);
    chk("pre-rst max", 32'(max_out), 32'd100);
    chk("pre-rst dir", 32'(direction_out), 32'd0);
    do_rst();
    chk_reset_vals();
    run_stream(50, 2, 206, 2, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
